// File: rtl/psram_capture_ctrl.sv
// Capture controller: streams ADC FIFO words into PSRAM, then dumps them back
// one word at a time through a valid/ready handshake.
module psram_capture_ctrl #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned CMD_TIMEOUT = 63
) (
   input  logic        mem_clk,
   input  logic        rst,
   input  logic        qpi_on,
   input  logic        arm,
   input  logic        dump_req,
   input  logic        fifo_empty,
   input  logic [15:0] fifo_dout,
   output logic        fifo_rd,
   input  logic        endcommand,
   input  logic [15:0] psram_data,
   output logic [22:0] address,
   output logic [1:0]  read_write,
   output logic        quad_start,
   output logic [15:0] data_in,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] W_POP   = 3'd1;
   localparam logic [2:0] W_LATCH = 3'd2;
   localparam logic [2:0] W_CMD   = 3'd3;
   localparam logic [2:0] W_WAIT  = 3'd4;
   localparam logic [2:0] R_CMD   = 3'd5;
   localparam logic [2:0] R_WAIT  = 3'd6;
   localparam logic [2:0] R_HOLD  = 3'd7;

   localparam int unsigned TW = (CMD_TIMEOUT < 2) ? 1 : $clog2(CMD_TIMEOUT);

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic          phase;
   logic [23:0]   word_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          start_w;
   logic          start_r;
   logic          tmo_hit;
   logic          w_last;
   logic          r_last;

   assign start_w = arm & qpi_on;
   assign start_r = dump_req & qpi_on & ~start_w;
   assign tmo_hit = (tmo_cnt == TW'(CMD_TIMEOUT - 1));
   assign w_last  = ((word_cnt + 24'd1) == 24'(DEPTH_WORDS));
   assign r_last  = (address == 23'(DEPTH_WORDS - 1));

   // Pop is combinational so the FIFO word lands exactly in W_LATCH.
   assign fifo_rd = (state == W_POP) & ~fifo_empty & qpi_on & ~rst;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_w) state_nxt = W_POP;
                  else if (start_r) state_nxt = R_CMD;
         W_POP:   if (!qpi_on) state_nxt = IDLE;
                  else if (!fifo_empty) state_nxt = W_LATCH;
         W_LATCH: state_nxt = W_CMD;
         W_CMD:   if (phase) state_nxt = W_WAIT;
         W_WAIT:  if (endcommand) state_nxt = (w_last || !qpi_on) ? IDLE : W_POP;
                  else if (tmo_hit) state_nxt = IDLE;
         R_CMD:   if (phase) state_nxt = R_WAIT;
         R_WAIT:  if (endcommand) state_nxt = R_HOLD;
                  else if (tmo_hit) state_nxt = IDLE;
         R_HOLD:  if (rd_ready) state_nxt = (r_last || !qpi_on) ? IDLE : R_CMD;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge mem_clk) begin
      if (rst) begin
         state      <= IDLE;
         phase      <= 1'b0;
         word_cnt   <= '0;
         tmo_cnt    <= '0;
         address    <= '0;
         read_write <= '0;
         quad_start <= 1'b0;
         data_in    <= '0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         state      <= state_nxt;
         busy       <= (state_nxt != IDLE);
         done       <= 1'b0;
         phase      <= ((state == W_CMD) || (state == R_CMD)) & ~phase;
         quad_start <= (state_nxt == W_CMD) || (state_nxt == R_CMD);
         tmo_cnt    <= ((state == W_WAIT) || (state == R_WAIT)) ? tmo_cnt + TW'(1) : '0;
         case (state_nxt)
            W_CMD, W_WAIT: read_write <= 2'd1;
            R_CMD, R_WAIT: read_write <= 2'd2;
            default:       read_write <= 2'd0;
         endcase

         case (state)
            IDLE: begin
               if (start_w || start_r) begin
                  address  <= '0;
                  word_cnt <= '0;
                  error    <= 1'b0;
               end
            end
            W_POP:   if (!qpi_on) error <= 1'b1;
            W_LATCH: data_in <= fifo_dout;
            W_WAIT: begin
               if (endcommand) begin
                  word_cnt <= word_cnt + 24'd1;
                  if (!qpi_on) error <= 1'b1;
                  else if (w_last) done <= 1'b1;
                  else address <= address + 23'd1;
               end else if (tmo_hit) begin
                  error <= 1'b1;
               end
            end
            R_WAIT: begin
               if (endcommand) begin
                  rd_data  <= psram_data;
                  rd_valid <= 1'b1;
               end else if (tmo_hit) begin
                  error    <= 1'b1;
                  rd_valid <= 1'b0;
               end
            end
            R_HOLD: begin
               if (rd_ready) begin
                  rd_valid <= 1'b0;
                  if (!qpi_on) error <= 1'b1;
                  else if (r_last) done <= 1'b1;
                  else address <= address + 23'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_psram_capture_ctrl.sv
// Randomized bench for psram_capture_ctrl: FIFO, PSRAM driver and UART sink
// models plus a word-level scoreboard of what must be written and read back.
module tb_psram_capture_ctrl;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TMO   = 20;
   localparam int unsigned LAT   = 12;

   logic        clk = 1'b0;
   logic        rst, qpi_on, arm, dump_req, fifo_empty, fifo_rd, endcommand;
   logic [15:0] fifo_dout, psram_data, data_in, rd_data;
   logic [22:0] address;
   logic [1:0]  read_write;
   logic        quad_start, rd_valid, rd_ready, busy, done, error;

   psram_capture_ctrl #(.DEPTH_WORDS(DEPTH), .CMD_TIMEOUT(TMO)) dut (
      .mem_clk(clk), .rst(rst), .qpi_on(qpi_on), .arm(arm), .dump_req(dump_req),
      .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd(fifo_rd),
      .endcommand(endcommand), .psram_data(psram_data), .address(address),
      .read_write(read_write), .quad_start(quad_start), .data_in(data_in),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy),
      .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [15:0] fifo_q [$];
   logic [15:0] exp_wr [$];
   logic [15:0] cap_words [4];
   logic [15:0] mem [0:7];

   int unsigned pops, wr_idx, rd_cmds, rd_hs, dones, qs_run, qs_total;
   int unsigned gap, hold_n, wcnt, cd, cyc, fall_cyc, err_cyc;
   bit          withhold, saw_busy;
   bit          s_fifo_rd, s_rise, s_rv, s_busy, p_qs, p_rv, p_rr, p_err;
   logic [15:0] p_rd;
   logic [2:0]  lat_addr;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: observe at negedge, then update input models just after posedge.
   task automatic cycle();
      @(negedge clk);
      s_fifo_rd = fifo_rd;
      s_rise    = quad_start && !p_qs;
      if (fifo_rd) pops++;
      if (quad_start) begin qs_run++; qs_total++; end
      if (s_rise) begin
         if (read_write == 2'd1) begin
            check("wr_addr", 64'(address), 64'(wr_idx));
            check("wr_data", 64'(data_in), (wr_idx < exp_wr.size()) ? 64'(exp_wr[wr_idx]) : 64'hdead);
            mem[address[2:0]] = data_in;
            wr_idx++;
         end else begin
            check("rd_cmd_rw", 64'(read_write), 64'd2);
            check("rd_addr", 64'(address), 64'(rd_cmds));
            lat_addr = address[2:0];
            rd_cmds++;
         end
      end
      if (!quad_start && p_qs) begin
         check("qs_len", 64'(qs_run), 64'd2);
         qs_run   = 0;
         fall_cyc = cyc;
      end
      if (p_rv && !p_rr) begin
         check("rv_hold", 64'(rd_valid), 64'd1);
         check("rd_stable", 64'(rd_data), 64'(p_rd));
      end
      if (rd_valid && rd_ready) begin
         check("rd_data", 64'(rd_data), 64'(cap_words[rd_hs % 4]));
         rd_hs++;
         wcnt = 0;
      end else if (rd_valid) begin
         wcnt++;
      end
      if (done) dones++;
      if (error && !p_err) err_cyc = cyc;
      p_qs = quad_start; p_rv = rd_valid; p_rr = rd_ready; p_rd = rd_data; p_err = error;
      s_rv = rd_valid; s_busy = busy;
      if (busy) saw_busy = 1'b1;

      @(posedge clk);
      #1;
      cyc++;
      if (s_fifo_rd && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
      if (gap > 0) gap--;
      fifo_empty = (fifo_q.size() == 0) || (gap > 0);
      endcommand = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            endcommand = 1'b1;
            psram_data = mem[lat_addr];
         end
      end
      if (s_rise && !withhold) cd = LAT;
      rd_ready = s_rv && (wcnt >= hold_n);
   endtask

   task automatic wait_idle(input string tag, input int unsigned limit, input bit stall);
      int unsigned n = 0;
      int unsigned mark = 0;
      bit stalled = 1'b0;
      bit st_chk = 1'b0;
      while (!(saw_busy && !s_busy) && n < limit) begin
         cycle();
         n++;
         if (stall && !stalled && pops == 2) begin
            gap = 40; fifo_empty = 1'b1; stalled = 1'b1;
         end
         if (stalled && gap == 20) mark = qs_total;
         if (stalled && gap == 0 && !st_chk) begin
            check("stall_qs", 64'(qs_total - mark), 64'd0);
            check("stall_pops", 64'(pops), 64'd2);
            st_chk = 1'b1;
         end
      end
      check(tag, 64'(!(saw_busy && !s_busy)), 64'd0);
   endtask

   task automatic do_capture(input bit fixed, input bit both, input bit stall);
      logic [15:0] w;
      exp_wr.delete();
      pops = 0; wr_idx = 0; dones = 0;
      for (int i = 0; i < 4; i++) begin
         w = fixed ? 16'(32'h1111 * (i + 1)) : 16'($urandom);
         fifo_q.push_back(w);
         exp_wr.push_back(w);
      end
      fifo_empty = 1'b0;
      saw_busy = 1'b0;
      arm = 1'b1; dump_req = both;
      cycle();
      arm = 1'b0; dump_req = 1'b0;
      wait_idle("cap_bound", 600, stall);
      check("cap_pops", 64'(pops), 64'd4);
      check("cap_writes", 64'(wr_idx), 64'd4);
      check("cap_done", 64'(dones), 64'd1);
      check("cap_error", 64'(error), 64'd0);
      for (int i = 0; i < 4; i++) cap_words[i] = exp_wr[i];
   endtask

   task automatic do_dump(input int unsigned hold);
      rd_hs = 0; rd_cmds = 0; dones = 0; hold_n = hold;
      saw_busy = 1'b0;
      dump_req = 1'b1;
      cycle();
      dump_req = 1'b0;
      wait_idle("dump_bound", 800, 1'b0);
      check("dump_words", 64'(rd_hs), 64'd4);
      check("dump_cmds", 64'(rd_cmds), 64'd4);
      check("dump_done", 64'(dones), 64'd1);
      check("dump_rv", 64'(rd_valid), 64'd0);
   endtask

   function automatic logic [63:0] outs();
      return 64'({address, read_write, quad_start, fifo_rd, data_in, rd_data,
                  rd_valid, busy, done, error});
   endfunction

   initial begin
      int unsigned n;
      int unsigned qs_mark;
      rst = 1'b1; qpi_on = 1'b1; arm = 1'b0; dump_req = 1'b0; fifo_empty = 1'b1;
      fifo_dout = '0; endcommand = 1'b0; psram_data = '0; rd_ready = 1'b0;
      pops = 0; wr_idx = 0; rd_cmds = 0; rd_hs = 0; dones = 0; qs_run = 0; qs_total = 0;
      gap = 0; hold_n = 5; wcnt = 0; cd = 0; cyc = 0; fall_cyc = 0; err_cyc = 0;
      withhold = 1'b0; saw_busy = 1'b0; s_rv = 1'b0; s_busy = 1'b0;
      p_qs = 1'b0; p_rv = 1'b0; p_rr = 1'b0; p_err = 1'b0; p_rd = '0; lat_addr = '0;
      for (int i = 0; i < 8; i++) mem[i] = '0;
      for (int i = 0; i < 4; i++) cap_words[i] = '0;

      repeat (3) cycle();
      check("reset_outs", outs(), 64'd0);
      rst = 1'b0;
      repeat (2) cycle();

      // fixed pattern capture with a FIFO underrun mid-run, then slow readback
      do_capture(1'b1, 1'b0, 1'b1);
      do_dump(5);

      // timeout: driver never answers the first write
      withhold = 1'b1;
      fifo_q.push_back(16'habcd);
      exp_wr.delete(); exp_wr.push_back(16'habcd);
      pops = 0; wr_idx = 0; dones = 0; fifo_empty = 1'b0;
      arm = 1'b1; cycle(); arm = 1'b0;
      n = 0;
      while (!p_err && n < 200) begin cycle(); n++; end
      check("tmo_bound", 64'(!p_err), 64'd0);
      check("tmo_cycles", 64'(err_cyc - fall_cyc), 64'(TMO));
      repeat (3) cycle();
      check("tmo_busy", 64'(busy), 64'd0);
      check("tmo_done", 64'(dones), 64'd0);
      check("tmo_error_sticky", 64'(error), 64'd1);
      withhold = 1'b0;
      fifo_q.delete();
      fifo_empty = 1'b1;

      // arm ignored while PSRAM not initialised
      qpi_on = 1'b0; pops = 0;
      arm = 1'b1; cycle(); arm = 1'b0;
      repeat (5) cycle();
      check("noqpi_busy", 64'(busy), 64'd0);
      check("noqpi_pops", 64'(pops), 64'd0);
      check("noqpi_error", 64'(error), 64'd1);
      qpi_on = 1'b1;

      // arm and dump_req together: capture wins and error clears
      do_capture(1'b0, 1'b1, 1'b0);
      do_dump(2);

      for (int r = 0; r < 3; r++) begin
         do_capture(1'b0, 1'b0, 1'($urandom_range(0, 1)));
         do_dump($urandom_range(0, 6));
      end

      // reset while a read word is being held
      hold_n = 1000; rd_hs = 0; rd_cmds = 0;
      dump_req = 1'b1; cycle(); dump_req = 1'b0;
      n = 0;
      while (!p_rv && n < 100) begin cycle(); n++; end
      check("hold_bound", 64'(!p_rv), 64'd0);
      rst = 1'b1;
      cycle();
      check("rst_hold_outs", outs(), 64'd0);
      rst = 1'b0;
      p_rv = 1'b0; p_qs = 1'b0; qs_run = 0; cd = 0; wcnt = 0; hold_n = 5; rd_ready = 1'b0;
      qs_mark = qs_total; pops = 0;
      repeat (6) cycle();
      check("post_rst_busy", 64'(busy), 64'd0);
      check("post_rst_qs", 64'(qs_total - qs_mark), 64'd0);
      check("post_rst_pops", 64'(pops), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
